// File: rtl/if_fetch_stage.sv
// ============================================================================
// Module   : if_fetch_stage
// Purpose  : Instruction fetch stage. Owns the PC, issues one outstanding
//            fetch at a time and drives the IF/ID register. Build macro
//            IF_MISALIGN_TRAP_EN adds a misaligned-redirect fault output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        id_stall_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] id_ir_o,
  output logic [31:0] id_pc_o,
  output logic        id_valid_o
`ifdef IF_MISALIGN_TRAP_EN
  ,
  output logic        if_fault_o
`endif
);

  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_WAIT  = 3'd1,
    S_BUF   = 3'd2,
    S_DRAIN = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] buf_ir_q, buf_ir_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] id_ir_q, id_ir_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        id_valid_q, id_valid_d;
  logic        fault_q, fault_d;

  logic        id_accept;
  logic        in_flight;
  logic        misalign;
  logic [31:0] redir_target;
  state_e      drain_exit;

  assign id_accept    = !id_valid_q || !id_stall_i;
  assign redir_target = redirect_pc_i & 32'hFFFF_FFFC;

  // A response is still owed by memory after this edge.
  assign in_flight = ((state_q == S_REQ) && imem_gnt_i) ||
                     (((state_q == S_WAIT) || (state_q == S_DRAIN)) && !imem_rvalid_i);

`ifdef IF_MISALIGN_TRAP_EN
  assign misalign   = (redirect_pc_i[1:0] != 2'b00);
  assign drain_exit = fault_q ? S_FAULT : S_REQ;
  assign if_fault_o = fault_q;
`else
  assign misalign   = 1'b0;
  assign drain_exit = S_REQ;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    buf_ir_d   = buf_ir_q;
    buf_pc_d   = buf_pc_q;
    id_ir_d    = id_ir_q;
    id_pc_d    = id_pc_q;
    id_valid_d = id_valid_q;
    fault_d    = fault_q;

    if (id_valid_q && !id_stall_i) begin
      id_valid_d = 1'b0;
      id_ir_d    = NOP_INSN;
    end

    case (state_q)
      S_REQ: begin
        if (imem_gnt_i) begin
          pc_d       = pc_q + 32'd4;
          fetch_pc_d = pc_q;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          if (id_accept) begin
            id_ir_d    = imem_rdata_i;
            id_pc_d    = fetch_pc_q;
            id_valid_d = 1'b1;
            state_d    = S_REQ;
          end else begin
            buf_ir_d = imem_rdata_i;
            buf_pc_d = fetch_pc_q;
            state_d  = S_BUF;
          end
        end
      end
      S_BUF: begin
        if (!id_stall_i) begin
          id_ir_d    = buf_ir_q;
          id_pc_d    = buf_pc_q;
          id_valid_d = 1'b1;
          state_d    = S_REQ;
        end
      end
      S_DRAIN: begin
        if (imem_rvalid_i) state_d = drain_exit;
      end
      S_FAULT: begin
        id_valid_d = 1'b0;
      end
      default: state_d = S_REQ;
    endcase

    // Redirect wins over everything, including a pending stall or buffered word.
    if (redirect_valid_i) begin
      id_valid_d = 1'b0;
      id_ir_d    = NOP_INSN;
      pc_d       = redir_target;
      fault_d    = misalign;
      if (in_flight)     state_d = S_DRAIN;
      else if (misalign) state_d = S_FAULT;
      else               state_d = S_REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      buf_ir_q   <= NOP_INSN;
      buf_pc_q   <= 32'h0;
      id_ir_q    <= NOP_INSN;
      id_pc_q    <= 32'h0;
      id_valid_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      buf_ir_q   <= buf_ir_d;
      buf_pc_q   <= buf_pc_d;
      id_ir_q    <= id_ir_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
      fault_q    <= fault_d;
    end
  end

  assign imem_req_o  = (state_q == S_REQ) && !rst;
  assign imem_addr_o = pc_q;
  assign id_ir_o     = id_ir_q;
  assign id_pc_o     = id_pc_q;
  assign id_valid_o  = id_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
// ============================================================================
// Module   : tb_if_fetch_stage
// Purpose  : Self-checking bench for if_fetch_stage with a latency-configurable
//            memory model and an in-order scoreboard of fetched instructions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_fetch_stage;

  localparam logic [31:0] C_NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] id_ir;
  logic [31:0] id_pc;
  logic        id_valid;
`ifdef IF_MISALIGN_TRAP_EN
  logic        if_fault;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int n_consumed = 0;

  logic        gnt_en;
  int          lat;
  logic        pend;
  int          cnt;
  logic [31:0] pdata;
  logic [63:0] exp_q[$];

  if_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSN (32'h0000_0013)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req_o       (imem_req),
    .imem_addr_o      (imem_addr),
    .imem_gnt_i       (imem_gnt),
    .imem_rvalid_i    (imem_rvalid),
    .imem_rdata_i     (imem_rdata),
    .id_stall_i       (id_stall),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .id_ir_o          (id_ir),
    .id_pc_o          (id_pc),
    .id_valid_o       (id_valid)
`ifdef IF_MISALIGN_TRAP_EN
    ,.if_fault_o      (if_fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return 32'h0050_0093 + {a[11:0], 20'h0};
  endfunction

  // Memory model: grant when enabled, respond lat cycles after the grant.
  assign imem_gnt    = imem_req && gnt_en;
  assign imem_rvalid = pend && (cnt == 0);
  assign imem_rdata  = imem_rvalid ? pdata : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0;
      cnt  <= 0;
      exp_q.delete();
    end else begin
      if (imem_req && imem_gnt) begin
        pend  <= 1'b1;
        cnt   <= lat - 1;
        pdata <= memw(imem_addr);
      end else if (pend) begin
        if (cnt == 0) pend <= 1'b0;
        else          cnt  <= cnt - 1;
      end
      if (redirect_valid) exp_q.delete();
      else if (imem_req && imem_gnt) exp_q.push_back({imem_addr, memw(imem_addr)});
    end
  end

  // Every instruction ID consumes must be the oldest live fetch, in order.
  always @(negedge clk) begin
    if (!rst && id_valid && !id_stall && !redirect_valid) begin
      n_tests++;
      n_consumed++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got pc=%h ir=%h, expected no instruction", id_pc, id_ir);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({id_pc, id_ir} !== e) begin
          n_fail++;
          $display("FAIL sb_order: got pc=%h ir=%h, expected pc=%h ir=%h",
                   id_pc, id_ir, e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; id_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    gnt_en = 1'b0; lat = 1;
    tick(); tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; id_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    gnt_en = 1'b0; lat = 1;
    tick(); tick();
    n_tests++;
    if ({imem_req, imem_addr, id_valid, id_ir, id_pc} !== {1'b0, 32'h0, 1'b0, C_NOP, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_state: got req=%b addr=%h v=%b ir=%h pc=%h, expected 0 0 0 %h 0",
               imem_req, imem_addr, id_valid, id_ir, id_pc, C_NOP);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_first_req: got req=%b addr=%h, expected 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_gnt_hold();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if ({imem_req, imem_addr, id_valid} !== {1'b1, 32'h0, 1'b0}) begin
        n_fail++;
        $display("FAIL gnt_hold[%0d]: got req=%b addr=%h v=%b, expected 1 00000000 0",
                 i, imem_req, imem_addr, id_valid);
      end
      tick();
    end
  endtask

  task automatic test_fetch();
    apply_reset();
    gnt_en = 1'b1;
    tick();
    n_tests++;
    if (imem_req !== 1'b0) begin
      n_fail++; $display("FAIL fetch_wait_req: got %b, expected 0", imem_req);
    end
    tick();
    n_tests++;
    if ({id_valid, id_ir, id_pc, imem_req, imem_addr} !== {1'b1, 32'h0050_0093, 32'h0, 1'b1, 32'h4}) begin
      n_fail++;
      $display("FAIL fetch_first: got v=%b ir=%h pc=%h req=%b addr=%h, expected 1 00500093 0 1 4",
               id_valid, id_ir, id_pc, imem_req, imem_addr);
    end
    tick();
    n_tests++;
    if ({id_valid, id_ir} !== {1'b0, C_NOP}) begin
      n_fail++; $display("FAIL fetch_consume: got v=%b ir=%h, expected 0 %h", id_valid, id_ir, C_NOP);
    end
    tick();
    n_tests++;
    if ({id_valid, id_ir, id_pc, imem_req, imem_addr} !== {1'b1, memw(32'h4), 32'h4, 1'b1, 32'h8}) begin
      n_fail++;
      $display("FAIL fetch_second: got v=%b ir=%h pc=%h req=%b addr=%h, expected 1 %h 4 1 8",
               id_valid, id_ir, id_pc, imem_req, imem_addr, memw(32'h4));
    end
  endtask

  // Brings the stage to: word 0 stalled in IF/ID, word 4 held in the buffer.
  task automatic stall_to_buf();
    apply_reset();
    gnt_en = 1'b1;
    tick(); tick();
    id_stall = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({imem_req, id_valid, id_ir, id_pc} !== {1'b0, 1'b1, memw(32'h0), 32'h0}) begin
      n_fail++;
      $display("FAIL stall_hold: got req=%b v=%b ir=%h pc=%h, expected 0 1 %h 0",
               imem_req, id_valid, id_ir, id_pc, memw(32'h0));
    end
  endtask

  task automatic test_stall();
    stall_to_buf();
    tick();
    n_tests++;
    if ({imem_req, id_ir, id_pc} !== {1'b0, memw(32'h0), 32'h0}) begin
      n_fail++;
      $display("FAIL stall_hold2: got req=%b ir=%h pc=%h, expected 0 %h 0", imem_req, id_ir, id_pc, memw(32'h0));
    end
    id_stall = 1'b0;
    tick();
    n_tests++;
    if ({id_valid, id_ir, id_pc, imem_req, imem_addr} !== {1'b1, memw(32'h4), 32'h4, 1'b1, 32'h8}) begin
      n_fail++;
      $display("FAIL stall_release: got v=%b ir=%h pc=%h req=%b addr=%h, expected 1 %h 4 1 8",
               id_valid, id_ir, id_pc, imem_req, imem_addr, memw(32'h4));
    end
  endtask

  task automatic test_redirect_wait();
    apply_reset();
    gnt_en = 1'b1; lat = 3;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0; lat = 1;
    n_tests++;
    if ({id_valid, id_ir, imem_req} !== {1'b0, C_NOP, 1'b0}) begin
      n_fail++;
      $display("FAIL redir_wait_flush: got v=%b ir=%h req=%b, expected 0 %h 0", id_valid, id_ir, imem_req, C_NOP);
    end
    tick(); tick();
    n_tests++;
    if ({id_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h100}) begin
      n_fail++;
      $display("FAIL redir_wait_refetch: got v=%b req=%b addr=%h, expected 0 1 100", id_valid, imem_req, imem_addr);
    end
    tick(); tick();
    n_tests++;
    if ({id_valid, id_ir, id_pc} !== {1'b1, memw(32'h100), 32'h100}) begin
      n_fail++;
      $display("FAIL redir_wait_target: got v=%b ir=%h pc=%h, expected 1 %h 100", id_valid, id_ir, id_pc, memw(32'h100));
    end
  endtask

  task automatic test_redirect_buf();
    stall_to_buf();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    n_tests++;
    if ({id_valid, id_ir, imem_req, imem_addr} !== {1'b0, C_NOP, 1'b1, 32'h100}) begin
      n_fail++;
      $display("FAIL redir_buf_flush: got v=%b ir=%h req=%b addr=%h, expected 0 %h 1 100",
               id_valid, id_ir, imem_req, imem_addr, C_NOP);
    end
    redirect_valid = 1'b0; id_stall = 1'b0;
    tick(); tick();
    n_tests++;
    if ({id_valid, id_ir, id_pc} !== {1'b1, memw(32'h100), 32'h100}) begin
      n_fail++;
      $display("FAIL redir_buf_target: got v=%b ir=%h pc=%h, expected 1 %h 100", id_valid, id_ir, id_pc, memw(32'h100));
    end
  endtask

  task automatic test_misalign();
    apply_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0; gnt_en = 1'b1;
`ifdef IF_MISALIGN_TRAP_EN
    n_tests++;
    if ({if_fault, imem_req, id_valid} !== {1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL misalign_fault: got fault=%b req=%b v=%b, expected 1 0 0", if_fault, imem_req, id_valid);
    end
    tick(); tick();
    n_tests++;
    if ({if_fault, imem_req} !== {1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL misalign_hold: got fault=%b req=%b, expected 1 0", if_fault, imem_req);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    n_tests++;
    if ({if_fault, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h200}) begin
      n_fail++;
      $display("FAIL misalign_recover: got fault=%b req=%b addr=%h, expected 0 1 200", if_fault, imem_req, imem_addr);
    end
    tick(); tick();
    n_tests++;
    if ({id_valid, id_pc, id_ir} !== {1'b1, 32'h200, memw(32'h200)}) begin
      n_fail++;
      $display("FAIL misalign_target: got v=%b pc=%h ir=%h, expected 1 200 %h", id_valid, id_pc, id_ir, memw(32'h200));
    end
`else
    n_tests++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin
      n_fail++;
      $display("FAIL misalign_ignored: got req=%b addr=%h, expected 1 100", imem_req, imem_addr);
    end
    tick(); tick();
    n_tests++;
    if ({id_valid, id_pc, id_ir} !== {1'b1, 32'h100, memw(32'h100)}) begin
      n_fail++;
      $display("FAIL misalign_target: got v=%b pc=%h ir=%h, expected 1 100 %h", id_valid, id_pc, id_ir, memw(32'h100));
    end
`endif
  endtask

  task automatic test_back_to_back();
    int start_consumed;
    apply_reset();
    start_consumed = n_consumed;
    for (int i = 0; i < 400; i++) begin
      gnt_en         = ($urandom_range(0, 3) != 0);
      lat            = $urandom_range(1, 3);
      id_stall       = ($urandom_range(0, 2) == 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = 32'($urandom_range(0, 255)) << 2;
      tick();
    end
    gnt_en = 1'b0; id_stall = 1'b0; redirect_valid = 1'b0;
    repeat (8) tick();
    n_tests++;
    if ({exp_q.size() == 0, id_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_drain: got pending=%0d v=%b, expected 0 0", exp_q.size(), id_valid);
    end
    n_tests++;
    if (n_consumed - start_consumed < 20) begin
      n_fail++;
      $display("FAIL b2b_progress: got %0d consumed, expected at least 20", n_consumed - start_consumed);
    end
  endtask

  initial begin
    test_reset();
    test_gnt_hold();
    test_fetch();
    test_stall();
    test_redirect_wait();
    test_redirect_buf();
    test_misalign();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
